// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared constants and helpers for the scanned BCD display
package bcd_disp_pkg;

   localparam int NUM_POS    = 6;
   localparam int NUM_DIGITS = 5;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_ERR   = 7'h06;

   // Active-low {g,f,e,d,c,b,a} glyphs for decimal digits
   localparam logic [6:0] SEG_DIG_0 = 7'h40;
   localparam logic [6:0] SEG_DIG_1 = 7'h79;
   localparam logic [6:0] SEG_DIG_2 = 7'h24;
   localparam logic [6:0] SEG_DIG_3 = 7'h30;
   localparam logic [6:0] SEG_DIG_4 = 7'h19;
   localparam logic [6:0] SEG_DIG_5 = 7'h12;
   localparam logic [6:0] SEG_DIG_6 = 7'h02;
   localparam logic [6:0] SEG_DIG_7 = 7'h78;
   localparam logic [6:0] SEG_DIG_8 = 7'h00;
   localparam logic [6:0] SEG_DIG_9 = 7'h10;

   typedef logic [2:0] pos_t;

   localparam pos_t UNITS_POS = 3'd0;
   localparam pos_t SIGN_POS  = 3'd5;

   function automatic logic any_invalid(input logic [4*NUM_DIGITS-1:0] bcd);
      logic bad;
      bad = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (bcd[4*k +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - nibble to active-low seven-segment glyph
module seg7_decode
   import bcd_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_ERR;
      case (nibble)
         4'd0:    seg = SEG_DIG_0;
         4'd1:    seg = SEG_DIG_1;
         4'd2:    seg = SEG_DIG_2;
         4'd3:    seg = SEG_DIG_3;
         4'd4:    seg = SEG_DIG_4;
         4'd5:    seg = SEG_DIG_5;
         4'd6:    seg = SEG_DIG_6;
         4'd7:    seg = SEG_DIG_7;
         4'd8:    seg = SEG_DIG_8;
         4'd9:    seg = SEG_DIG_9;
         default: seg = SEG_ERR;
      endcase
   end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - six-position multiplexed 7-segment driver for signed BCD
module bcd_scan_display
   import bcd_disp_pkg::*;
#(
   parameter int DIV = 50000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [19:0] BCD_in,
   input  logic        neg_in,
   input  logic        en,
   output logic [6:0]  seg_out,
   output logic [5:0]  an_out,
   output logic        err_out
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

   logic [PW-1:0]   pcnt;
   pos_t            idx;
   logic [19:0]     val;
   logic            neg;
   logic            err;

   logic [NUM_DIGITS-1:0] nz;
   logic [NUM_DIGITS-1:0] keep;
   logic [3:0]            cur_nib;
   logic [6:0]            dig_seg;
   logic [6:0]            nxt_seg;
   logic [5:0]            nxt_an;
   logic                  slot_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val <= '0;
         neg <= 1'b0;
         err <= 1'b0;
      end else if (load) begin
         val <= BCD_in;
         neg <= neg_in;
         err <= any_invalid(BCD_in);
      end
   end

   assign slot_end = (pcnt == PCNT_LAST);

   // Scan position is independent of loads; only en gates it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt <= '0;
         idx  <= UNITS_POS;
      end else if (en) begin
         if (slot_end) begin
            pcnt <= '0;
            idx  <= (idx == SIGN_POS) ? UNITS_POS : idx + 3'd1;
         end else begin
            pcnt <= pcnt + 1'b1;
         end
      end
   end

   // keep[k]: some nibble at position k or above is nonzero, so k is not a leading zero
   always_comb begin
      nz = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         nz[k] = |val[4*k +: 4];
      end
      keep = nz;
      for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
         keep[k] = nz[k] | keep[k+1];
      end
   end

   always_comb begin
      cur_nib = 4'd0;
      case (idx)
         3'd0:    cur_nib = val[3:0];
         3'd1:    cur_nib = val[7:4];
         3'd2:    cur_nib = val[11:8];
         3'd3:    cur_nib = val[15:12];
         3'd4:    cur_nib = val[19:16];
         default: cur_nib = 4'd0;
      endcase
   end

   seg7_decode u_decode (
      .nibble (cur_nib),
      .seg    (dig_seg)
   );

   always_comb begin
      nxt_seg = SEG_BLANK;
      if (idx == SIGN_POS) begin
         nxt_seg = (neg && (|val)) ? SEG_MINUS : SEG_BLANK;
      end else if (idx == UNITS_POS) begin
         nxt_seg = dig_seg;
      end else if (idx < SIGN_POS) begin
         nxt_seg = keep[idx] ? dig_seg : SEG_BLANK;
      end
      nxt_an = en ? ~(6'b000001 << idx) : 6'h3F;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_out <= SEG_BLANK;
         an_out  <= 6'h3F;
         err_out <= 1'b0;
      end else begin
         seg_out <= nxt_seg;
         an_out  <= nxt_an;
         err_out <= err;
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - randomized and directed bench for bcd_scan_display
module tb_bcd_scan_display;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [19:0] BCD_in;
   logic        neg_in;
   logic        en;
   logic [6:0]  seg_out;
   logic [5:0]  an_out;
   logic        err_out;

   int checks = 0;
   int errors = 0;

   int m_val;
   bit m_neg;
   bit m_err;
   int m_ecnt;

   logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   bcd_scan_display #(.DIV(DIV)) dut (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .BCD_in  (BCD_in),
      .neg_in  (neg_in),
      .en      (en),
      .seg_out (seg_out),
      .an_out  (an_out),
      .err_out (err_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] model_seg(input int pos, input int v, input bit n);
      int d;
      if (pos == 5) return (n && v != 0) ? 7'h3F : 7'h7F;
      if (pos > 0 && (v >> (4 * pos)) == 0) return 7'h7F;
      d = (v >> (4 * pos)) & 15;
      return (d > 9) ? 7'h06 : glyph[d];
   endfunction

   function automatic logic [5:0] model_an(input int pos, input bit e);
      return e ? 6'(~(32'd1 << pos)) : 6'h3F;
   endfunction

   function automatic bit model_err(input int v);
      for (int k = 0; k < 5; k++) begin
         if (((v >> (4 * k)) & 15) > 9) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_val  = 0;
      m_neg  = 1'b0;
      m_err  = 1'b0;
      m_ecnt = 0;
   endtask

   task automatic step(input logic ld, input logic [19:0] bcd, input logic ng, input logic e);
      logic [6:0] es;
      logic [5:0] ea;
      logic       ee;
      int         pos;
      @(negedge clk);
      load   = ld;
      BCD_in = bcd;
      neg_in = ng;
      en     = e;
      pos = (m_ecnt / DIV) % 6;
      es  = model_seg(pos, m_val, m_neg);
      ea  = model_an(pos, e);
      ee  = m_err;
      if (ld) begin
         m_val = int'(bcd);
         m_neg = ng;
         m_err = model_err(m_val);
      end
      if (e) m_ecnt++;
      @(posedge clk);
      #1;
      check("seg", seg_out, es);
      check("an", an_out, ea);
      check("err", err_out, ee);
   endtask

   // tbl holds slot p glyph at tbl[7p +: 7]
   task automatic scan_slots(input string tag, input logic [41:0] tbl);
      int pos;
      repeat (6 * DIV) begin
         step(1'b0, 20'h0, 1'b0, 1'b1);
         pos = -1;
         for (int p = 0; p < 6; p++) begin
            if (an_out == 6'(~(32'd1 << p))) pos = p;
         end
         if (pos >= 0) check(tag, seg_out, tbl[7*pos +: 7]);
         else          check({tag, "_an"}, an_out, 6'h3E);
      end
   endtask

   task automatic align_to(input int phase);
      while ((m_ecnt % (6 * DIV)) != phase) step(1'b0, 20'h0, 1'b0, 1'b1);
   endtask

   task automatic release_reset();
      load = 1'b0;
      en   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [19:0] rv;
      int          nd;
      rst    = 1'b1;
      load   = 1'b0;
      BCD_in = '0;
      neg_in = 1'b0;
      en     = 1'b0;
      model_reset();
      #12;
      check("rst_seg", seg_out, 7'h7F);
      check("rst_an", an_out, 6'h3F);
      check("rst_err", err_out, 1'b0);
      release_reset();

      step(1'b0, 20'h0, 1'b0, 1'b1);
      check("first_an", an_out, 6'h3E);
      check("first_seg", seg_out, 7'h40);

      step(1'b1, 20'h01234, 1'b0, 1'b1);
      scan_slots("scan_01234", {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});

      // async reset between edges with a value loaded and mid-slot
      step(1'b0, 20'h0, 1'b0, 1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_seg", seg_out, 7'h7F);
      check("arst_an", an_out, 6'h3F);
      check("arst_err", err_out, 1'b0);
      model_reset();
      release_reset();
      step(1'b0, 20'h0, 1'b0, 1'b1);
      check("post_rst_an", an_out, 6'h3E);
      check("post_rst_seg", seg_out, 7'h40);

      step(1'b1, 20'h00521, 1'b1, 1'b1);
      scan_slots("scan_m521", {7'h3F, 7'h7F, 7'h7F, 7'h12, 7'h24, 7'h79});
      step(1'b1, 20'h32767, 1'b1, 1'b1);
      scan_slots("scan_m32767", {7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h78});
      step(1'b1, 20'h00000, 1'b1, 1'b1);
      scan_slots("scan_negzero", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

      step(1'b1, 20'h0A000, 1'b0, 1'b1);
      step(1'b0, 20'h0, 1'b0, 1'b1);
      check("err_after_load", err_out, 1'b1);
      scan_slots("scan_err", {7'h7F, 7'h7F, 7'h06, 7'h40, 7'h40, 7'h40});

      // pause in slot 2 with one count consumed
      step(1'b1, 20'h01234, 1'b0, 1'b1);
      align_to(2 * DIV + 1);
      repeat (3) begin
         step(1'b0, 20'h0, 1'b0, 1'b0);
         check("pause_an", an_out, 6'h3F);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 20'h0, 1'b0, 1'b1);
         check("resume_an", an_out, (i < 3) ? 6'h3B : 6'h37);
      end

      // load on the edge that wraps slot 5 back to slot 0
      align_to(6 * DIV - 1);
      step(1'b1, 20'h00009, 1'b0, 1'b1);
      step(1'b0, 20'h0, 1'b0, 1'b1);
      check("wrap_an", an_out, 6'h3E);
      check("wrap_seg", seg_out, 7'h10);

      for (int i = 0; i < 800; i++) begin
         rv = '0;
         for (int k = 0; k < 5; k++) begin
            rv[4*k +: 4] = ($urandom % 8 == 0) ? 4'($urandom % 16) : 4'($urandom % 10);
         end
         nd = $urandom_range(0, 5);
         if (nd < 5) rv = rv & ((20'h1 << (4 * nd)) - 20'h1);
         step(($urandom % 4) == 0, rv, 1'($urandom % 2), ($urandom % 8) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
